// File: rtl/inst_trace_ring.sv
// inst_trace_ring: debug trace ring for committed (pc, instr) pairs beside WB.
// Freezes POST_TRIG commits after a trigger and is read back through a
// registered index port. The read data is also returned as an ASCII mnemonic.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid, in_pc, in_instr     commit stream
//   trig_in, trig_mask            external trigger / self-trigger enables
//                                 (bit0 BREAK, bit1 SYSCALL, bit2 ERET)
//   arm                           clear the ring and re-arm
//   rd_req, rd_idx                read request, index 0 = oldest entry held
//   rd_valid, rd_ok, rd_pc,
//   rd_instr, rd_ascii            read response, one cycle after rd_req
//   count, frozen, trig_idx       fill level, frozen flag, trigger entry index
module inst_trace_ring #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned NCHARS    = 6,
   parameter int unsigned POST_TRIG = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [31:0]                in_pc,
   input  logic [31:0]                in_instr,
   input  logic                       trig_in,
   input  logic [2:0]                 trig_mask,
   input  logic                       arm,
   input  logic                       rd_req,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic                       rd_valid,
   output logic                       rd_ok,
   output logic [31:0]                rd_pc,
   output logic [31:0]                rd_instr,
   output logic [8*NCHARS-1:0]        rd_ascii,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       frozen,
   output logic [$clog2(DEPTH)-1:0]   trig_idx
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;
   localparam int unsigned AW = 8 * NCHARS;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   typedef enum logic [1:0] {ARMED, POST, FROZEN} state_t;

   state_t          state;
   logic [IW-1:0]   wr_ptr;
   logic [IW-1:0]   post_cnt;
   entry_t          mem [DEPTH];

   // Upper-case mnemonic, right-aligned in 6 bytes, upper bytes zero.
   function automatic logic [47:0] decode(input logic [31:0] ins);
      logic [47:0] m;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  rs;
      logic [4:0]  rt;
      op = ins[31:26];
      rs = ins[25:21];
      rt = ins[20:16];
      fn = ins[5:0];
      m  = 48'("N-R");
      case (op)
         6'h00: begin
            case (fn)
               6'h00: m = 48'("SLL");
               6'h02: m = 48'("SRL");
               6'h03: m = 48'("SRA");
               6'h04: m = 48'("SLLV");
               6'h06: m = 48'("SRLV");
               6'h07: m = 48'("SRAV");
               6'h08: m = 48'("JR");
               6'h09: m = 48'("JALR");
               6'h0C: m = 48'("SYSC");
               6'h0D: m = 48'("BREAK");
               6'h10: m = 48'("MFHI");
               6'h11: m = 48'("MTHI");
               6'h12: m = 48'("MFLO");
               6'h13: m = 48'("MTLO");
               6'h18: m = 48'("MULT");
               6'h19: m = 48'("MULTU");
               6'h1A: m = 48'("DIV");
               6'h1B: m = 48'("DIVU");
               6'h20: m = 48'("ADD");
               6'h21: m = 48'("ADDU");
               6'h22: m = 48'("SUB");
               6'h23: m = 48'("SUBU");
               6'h24: m = 48'("AND");
               6'h25: m = 48'("OR");
               6'h26: m = 48'("XOR");
               6'h27: m = 48'("NOR");
               6'h2A: m = 48'("SLT");
               6'h2B: m = 48'("SLTU");
               default: ;
            endcase
         end
         6'h01: begin
            case (rt)
               5'h00: m = 48'("BLTZ");
               5'h01: m = 48'("BGEZ");
               5'h10: m = 48'("BLTZAL");
               5'h11: m = 48'("BGEZAL");
               default: ;
            endcase
         end
         6'h10: begin
            case (rs)
               5'h04: m = 48'("MTC0");
               5'h00: m = 48'("MFC0");
               default: ;
            endcase
         end
         6'h02: m = 48'("J");
         6'h03: m = 48'("JAL");
         6'h04: m = 48'("BEQ");
         6'h05: m = 48'("BNE");
         6'h06: m = 48'("BLEZ");
         6'h07: m = 48'("BGTZ");
         6'h08: m = 48'("ADDI");
         6'h09: m = 48'("ADDIU");
         6'h0A: m = 48'("SLTI");
         6'h0B: m = 48'("SLTIU");
         6'h0C: m = 48'("ANDI");
         6'h0D: m = 48'("ORI");
         6'h0E: m = 48'("XORI");
         6'h0F: m = 48'("LUI");
         6'h20: m = 48'("LB");
         6'h21: m = 48'("LH");
         6'h23: m = 48'("LW");
         6'h24: m = 48'("LBU");
         6'h25: m = 48'("LHU");
         6'h28: m = 48'("SB");
         6'h29: m = 48'("SH");
         6'h2B: m = 48'("SW");
         default: ;
      endcase
      // NOP last so it outranks ERET and the SLL decode of an all-zero word
      if (ins == 32'h4200_0018) m = 48'("ERET");
      if (ins == 32'h0000_0000) m = 48'("NOP");
      return m;
   endfunction

   // Self/external trigger qualification for the current commit
   logic [47:0] in_mn;
   logic        trig_hit;
   always_comb begin
      in_mn    = decode(in_instr);
      trig_hit = trig_in
               | (trig_mask[0] & (in_mn == 48'("BREAK")))
               | (trig_mask[1] & (in_mn == 48'("SYSC")))
               | (trig_mask[2] & (in_instr == 32'h4200_0018));
   end

   logic          wr_en;
   logic [CW-1:0] count_nxt;
   always_comb begin
      wr_en     = in_valid & ~arm & (state != FROZEN);
      count_nxt = (count == CW'(DEPTH)) ? count : count + CW'(1);
   end

   // Read address: oldest physical slot is (wr_ptr - count) mod DEPTH
   logic          rd_hit;
   logic [IW-1:0] rd_phys;
   entry_t        rd_sel;
   always_comb begin
      rd_hit  = CW'(rd_idx) < count;
      rd_phys = wr_ptr - IW'(count) + rd_idx;
      rd_sel  = rd_hit ? mem[rd_phys] : '0;
   end

   // Ring storage, deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
   end

   // Control FSM, fill tracking and registered read port
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARMED;
         count    <= '0;
         wr_ptr   <= '0;
         trig_idx <= '0;
         post_cnt <= '0;
         rd_valid <= 1'b0;
         rd_ok    <= 1'b0;
         rd_pc    <= '0;
         rd_instr <= '0;
         rd_ascii <= '0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req) begin
            rd_ok    <= rd_hit;
            rd_pc    <= rd_sel.pc;
            rd_instr <= rd_sel.instr;
            rd_ascii <= AW'(decode(rd_sel.instr));
         end

         if (arm) begin
            state    <= ARMED;
            count    <= '0;
            wr_ptr   <= '0;
            trig_idx <= '0;
            post_cnt <= '0;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + IW'(1);
            count  <= count_nxt;
            case (state)
               ARMED: begin
                  if (trig_hit) begin
                     post_cnt <= '0;
                     if (POST_TRIG == 0) begin
                        state    <= FROZEN;
                        trig_idx <= IW'(count_nxt - CW'(1));
                     end else begin
                        state <= POST;
                     end
                  end
               end
               POST: begin
                  if (post_cnt == IW'(POST_TRIG - 1)) begin
                     state    <= FROZEN;
                     trig_idx <= IW'(count_nxt - CW'(1) - CW'(POST_TRIG));
                  end else begin
                     post_cnt <= post_cnt + IW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign frozen = (state == FROZEN);

endmodule

// File: tb/tb_inst_trace_ring.sv
// Directed bench for inst_trace_ring (DEPTH=16, NCHARS=6, POST_TRIG=4).
module tb_inst_trace_ring;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        trig_in;
   logic [2:0]  trig_mask;
   logic        arm;
   logic        rd_req;
   logic [3:0]  rd_idx;
   logic        rd_valid;
   logic        rd_ok;
   logic [31:0] rd_pc;
   logic [31:0] rd_instr;
   logic [47:0] rd_ascii;
   logic [4:0]  count;
   logic        frozen;
   logic [3:0]  trig_idx;

   int checks = 0;
   int errors = 0;

   inst_trace_ring #(.DEPTH(16), .NCHARS(6), .POST_TRIG(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
      .trig_in(trig_in), .trig_mask(trig_mask), .arm(arm), .rd_req(rd_req),
      .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_ok(rd_ok), .rd_pc(rd_pc),
      .rd_instr(rd_instr), .rd_ascii(rd_ascii), .count(count), .frozen(frozen),
      .trig_idx(trig_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic commit(input logic [31:0] pc, input logic [31:0] ins);
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = ins;
      step();
      in_valid = 1'b0;
   endtask

   task automatic rd(input logic [3:0] idx);
      rd_req = 1'b1;
      rd_idx = idx;
      step();
      rd_req = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   logic [31:0] sweep_ins [8];
   logic [47:0] sweep_asc [8];

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; trig_in = 1'b0;
      trig_mask = 3'b000; arm = 1'b0; rd_req = 1'b0; rd_idx = '0;
      repeat (3) step();
      rst = 1'b0;

      // Reset state
      check("rst_count", 64'(count), 64'd0);
      check("rst_frozen", 64'(frozen), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_trig_idx", 64'(trig_idx), 64'd0);
      check("rst_ascii", 64'(rd_ascii), 64'd0);

      // Empty read
      rd(4'd3);
      check("empty_valid", 64'(rd_valid), 64'd1);
      check("empty_ok", 64'(rd_ok), 64'd0);
      check("empty_pc", 64'(rd_pc), 64'd0);
      check("empty_ascii", 64'(rd_ascii), 64'(48'("NOP")));
      step();
      check("idle_valid", 64'(rd_valid), 64'd0);
      check("idle_hold", 64'(rd_ascii), 64'(48'("NOP")));

      // Decode sweep
      sweep_ins[0] = 32'h0000_0000; sweep_asc[0] = 48'("NOP");
      sweep_ins[1] = 32'h4200_0018; sweep_asc[1] = 48'("ERET");
      sweep_ins[2] = 32'h0411_0000; sweep_asc[2] = 48'("BGEZAL");
      sweep_ins[3] = 32'h4080_0000; sweep_asc[3] = 48'("MTC0");
      sweep_ins[4] = 32'hFC00_0000; sweep_asc[4] = 48'("N-R");
      sweep_ins[5] = 32'h0000_000C; sweep_asc[5] = 48'("SYSC");
      sweep_ins[6] = 32'h8C00_0000; sweep_asc[6] = 48'("LW");
      sweep_ins[7] = 32'h0402_0000; sweep_asc[7] = 48'("N-R");
      do_arm();
      for (int i = 0; i < 8; i++) commit(32'(i * 4), sweep_ins[i]);
      check("sweep_count", 64'(count), 64'd8);
      for (int i = 0; i < 8; i++) begin
         rd(4'(i));
         check($sformatf("sweep_asc%0d", i), 64'(rd_ascii), 64'(sweep_asc[i]));
         check($sformatf("sweep_ins%0d", i), 64'(rd_instr), 64'(sweep_ins[i]));
      end

      // Wrap: 20 commits, oldest is pc 16
      do_arm();
      for (int i = 0; i < 20; i++) commit(32'(i * 4), 32'h2400_0000 | 32'(i));
      check("wrap_count", 64'(count), 64'd16);
      check("wrap_frozen", 64'(frozen), 64'd0);
      rd(4'd0);
      check("wrap_pc0", 64'(rd_pc), 64'd16);
      check("wrap_ins0", 64'(rd_instr), 64'h2400_0004);
      check("wrap_asc0", 64'(rd_ascii), 64'(48'("ADDIU")));
      rd(4'd15);
      check("wrap_pc15", 64'(rd_pc), 64'd76);
      // Read the oldest slot while it is overwritten: old data returned
      rd_req = 1'b1; rd_idx = 4'd0;
      commit(32'd80, 32'h2400_0014);
      rd_req = 1'b0;
      check("samecyc_pc", 64'(rd_pc), 64'd16);
      check("samecyc_count", 64'(count), 64'd16);
      rd(4'd0);
      check("after_ovw_pc0", 64'(rd_pc), 64'd20);

      // BREAK self-trigger, commit 6 of 10
      do_arm();
      trig_mask = 3'b001;
      for (int i = 1; i <= 10; i++) begin
         commit(32'(i * 4), (i == 6) ? 32'h0000_000D : 32'h2400_0000);
         if (i == 6) check("brk_post_at6", 64'(frozen), 64'd0);
         if (i == 9) check("brk_post_at9", 64'(frozen), 64'd0);
      end
      check("brk_frozen", 64'(frozen), 64'd1);
      check("brk_count", 64'(count), 64'd10);
      check("brk_trig_idx", 64'(trig_idx), 64'd5);
      commit(32'd44, 32'h0000_000D);
      commit(32'd48, 32'h2400_0000);
      check("brk_ignored_count", 64'(count), 64'd10);
      rd(4'd5);
      check("brk_entry_asc", 64'(rd_ascii), 64'(48'("BREAK")));
      check("brk_entry_pc", 64'(rd_pc), 64'd24);
      rd(4'd9);
      check("brk_last_pc", 64'(rd_pc), 64'd40);
      rd(4'd10);
      check("brk_beyond_ok", 64'(rd_ok), 64'd0);

      // arm beats a same-cycle commit
      arm = 1'b1;
      commit(32'h999, 32'h2400_0000);
      arm = 1'b0;
      check("arm_count", 64'(count), 64'd0);
      check("arm_frozen", 64'(frozen), 64'd0);
      check("arm_trig_idx", 64'(trig_idx), 64'd0);
      rd(4'd0);
      check("arm_rd_ok", 64'(rd_ok), 64'd0);

      // External trigger on the first commit
      trig_mask = 3'b000;
      trig_in = 1'b1;
      commit(32'h100, 32'h2400_0000);
      trig_in = 1'b0;
      for (int i = 0; i < 4; i++) commit(32'h104 + 32'(i * 4), 32'h2400_0000);
      check("ext_frozen", 64'(frozen), 64'd1);
      check("ext_trig_idx", 64'(trig_idx), 64'd0);
      check("ext_count", 64'(count), 64'd5);

      // Reset mid-POST aborts capture
      do_arm();
      trig_mask = 3'b001;
      commit(32'h200, 32'h2400_0000);
      commit(32'h204, 32'h0000_000D);
      commit(32'h208, 32'h2400_0000);
      commit(32'h20C, 32'h2400_0000);
      check("midpost_count", 64'(count), 64'd4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midpost_rst_count", 64'(count), 64'd0);
      check("midpost_rst_frozen", 64'(frozen), 64'd0);
      trig_mask = 3'b000;
      for (int i = 0; i < 3; i++) commit(32'h300 + 32'(i * 4), 32'h2400_0000);
      check("midpost_armed_frozen", 64'(frozen), 64'd0);
      check("midpost_armed_count", 64'(count), 64'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
